// File: rtl/fetch_stage_if.sv
// fetch_stage_if -- signal bundle around the instruction fetch stage.
//
// Groups everything the fetch stage exchanges with its neighbours:
//   instruction memory : imem_req_o, imem_addr_o (fetch stage -> memory)
//                        imem_gnt_i, imem_valid_i, imem_rdata_i (memory -> fetch stage)
//   redirect           : redirect_i, redirect_pc_i (branch unit -> fetch stage)
//   decode handshake   : if_valid_o, if_pc_o, if_instr_o (fetch stage -> decode)
//                        id_ready_i (decode -> fetch stage)
//   misalign_o         : one-cycle pulse on a redirect to a non-word-aligned target
//
// The _i/_o suffixes are from the fetch stage's point of view.
// master = the fetch stage itself, slave = its environment.
interface fetch_stage_if #(
  parameter int unsigned DataWidth = 32
);
  logic                 imem_req_o;
  logic [DataWidth-1:0] imem_addr_o;
  logic                 imem_gnt_i;
  logic                 imem_valid_i;
  logic [DataWidth-1:0] imem_rdata_i;
  logic                 redirect_i;
  logic [DataWidth-1:0] redirect_pc_i;
  logic                 id_ready_i;
  logic                 if_valid_o;
  logic [DataWidth-1:0] if_pc_o;
  logic [DataWidth-1:0] if_instr_o;
  logic                 misalign_o;

  modport master (
    output imem_req_o, imem_addr_o, if_valid_o, if_pc_o, if_instr_o, misalign_o,
    input  imem_gnt_i, imem_valid_i, imem_rdata_i, redirect_i, redirect_pc_i, id_ready_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o, if_valid_o, if_pc_o, if_instr_o, misalign_o,
    output imem_gnt_i, imem_valid_i, imem_rdata_i, redirect_i, redirect_pc_i, id_ready_i
  );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage -- single-outstanding instruction fetch with one output slot.
//
// Ports:
//   clk  : rising-edge clock for all state
//   rst  : synchronous active-high reset
//   bus  : fetch_stage_if.master (instruction memory request/response,
//          redirect input, decode-side valid/ready slot, misalign pulse)
//
// A request is only issued when the output slot is empty or is being drained
// this cycle, so a response always lands in an empty slot and no skid buffer
// is needed. A redirect squashes the slot and, if a request is in flight,
// moves to DRAIN so the stale response is swallowed.
module fetch_stage #(
  parameter int unsigned          DataWidth   = 32,
  parameter logic [DataWidth-1:0] ResetVector = DataWidth'(32'h0000_0000)
) (
  input logic           clk,
  input logic           rst,
  fetch_stage_if.master bus
);

  localparam logic [DataWidth-1:0] Nop = DataWidth'(32'h0000_0013);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [DataWidth-1:0] pc_q, pc_d;
  logic [DataWidth-1:0] inflight_pc_q, inflight_pc_d;
  logic [DataWidth-1:0] if_pc_q, if_pc_d;
  logic [DataWidth-1:0] if_instr_q, if_instr_d;
  logic                 if_valid_q, if_valid_d;
  logic                 misalign_q, misalign_d;

  logic                 req;
  logic                 fire;
  logic                 load;
  logic [DataWidth-1:0] redirect_target;

  assign redirect_target = {bus.redirect_pc_i[DataWidth-1:2], 2'b00};
  assign fire            = req && bus.imem_gnt_i;
  // A response is only accepted into the slot when no redirect squashes it.
  assign load            = (state_q == WAIT) && bus.imem_valid_i && !bus.redirect_i;

  // ---------------------------------------------------------------- state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------- next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        // A grant coinciding with a redirect carries the old PC: drain it.
        if (fire)                 state_d = bus.redirect_i ? DRAIN : WAIT;
        else                      state_d = REQ;
      end
      WAIT: begin
        if (bus.imem_valid_i)     state_d = REQ;
        else if (bus.redirect_i)  state_d = DRAIN;
      end
      DRAIN: begin
        // The stale response ends the drain even if another redirect arrives
        // with it; that redirect only updates pc.
        if (bus.imem_valid_i)     state_d = REQ;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- outputs
  always_comb begin
    req              = !rst && (state_q == REQ) && (!if_valid_q || bus.id_ready_i);
    bus.imem_req_o   = req;
    bus.imem_addr_o  = pc_q;
    bus.if_valid_o   = if_valid_q;
    bus.if_pc_o      = if_pc_q;
    bus.if_instr_o   = if_instr_q;
    bus.misalign_o   = misalign_q;
  end

  // ---------------------------------------------------------------- datapath next values
  always_comb begin
    pc_d          = pc_q;
    inflight_pc_d = inflight_pc_q;
    if_pc_d       = if_pc_q;
    if_instr_d    = if_instr_q;
    if_valid_d    = if_valid_q;
    misalign_d    = bus.redirect_i && (bus.redirect_pc_i[1:0] != 2'b00);

    if (fire) begin
      inflight_pc_d = pc_q;
    end

    if (if_valid_q && bus.id_ready_i) begin
      if_valid_d = 1'b0;
    end

    if (load) begin
      if_valid_d = 1'b1;
      if_pc_d    = inflight_pc_q;
      if_instr_d = bus.imem_rdata_i;
      pc_d       = inflight_pc_q + DataWidth'(4);
    end

    // Redirect wins over everything else in the same cycle.
    if (bus.redirect_i) begin
      pc_d       = redirect_target;
      if_valid_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------- datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= ResetVector;
      inflight_pc_q <= '0;
      if_pc_q       <= '0;
      if_instr_q    <= Nop;
      if_valid_q    <= 1'b0;
      misalign_q    <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      inflight_pc_q <= inflight_pc_d;
      if_pc_q       <= if_pc_d;
      if_instr_q    <= if_instr_d;
      if_valid_q    <= if_valid_d;
      misalign_q    <= misalign_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage -- self-checking bench for fetch_stage.
// A behavioural memory answers grants after a configurable latency; a
// transaction-level model (outstanding/stale flags, one output slot) predicts
// every output each cycle. Directed scenarios check fixed expected values.
module tb_fetch_stage;

  localparam logic [31:0] RV  = 32'h0000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_stage_if #(.DataWidth(32)) bus ();

  fetch_stage #(.DataWidth(32), .ResetVector(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int passed = 0;
  int total  = 0;

  // stimulus controls
  logic        drv_rst = 1'b1, drv_redirect = 1'b0, drv_ready = 1'b1, drv_gnt = 1'b1;
  logic [31:0] drv_target = '0;
  int          mem_lat = 1;
  bit          mem_lat_rand = 0;
  bit          mem_force = 0;
  logic [31:0] mem_force_data = '0;

  // memory state
  bit          mem_busy = 0;
  logic [31:0] mem_addr = '0;
  int          mem_cnt = 0;

  // reference model state
  bit          m_started = 0, m_out = 0, m_stale = 0, m_sv = 0, m_mis = 0;
  logic [31:0] m_pc = RV, m_inflight = '0, m_spc = '0, m_sinstr = NOP;

  // observed / expected values of the cycle just executed (sampled before its edge)
  logic        obs_req, obs_v, obs_mis, exp_req, exp_v, exp_mis;
  logic [31:0] obs_addr, obs_pc, obs_instr, exp_addr, exp_pc, exp_instr;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // One clock cycle: drive at the negedge, sample 1ns later, then advance
  // memory and model to their post-edge state.
  task automatic tick();
    bit granted, arrived;
    int lat;
    rst               = drv_rst;
    bus.redirect_i    = drv_redirect;
    bus.redirect_pc_i = drv_target;
    bus.id_ready_i    = drv_ready;
    bus.imem_gnt_i    = drv_gnt;
    bus.imem_valid_i  = mem_busy && (mem_cnt == 0);
    bus.imem_rdata_i  = mem_force ? mem_force_data : word_at(mem_addr);
    #1;
    obs_req = bus.imem_req_o;  obs_addr = bus.imem_addr_o; obs_v   = bus.if_valid_o;
    obs_pc  = bus.if_pc_o;     obs_instr = bus.if_instr_o; obs_mis = bus.misalign_o;
    exp_req = !drv_rst && m_started && !m_out && (!m_sv || drv_ready);
    exp_addr = m_pc; exp_v = m_sv; exp_pc = m_spc; exp_instr = m_sinstr; exp_mis = m_mis;

    // memory
    if (drv_rst) begin
      mem_busy = 0;
    end else begin
      if (bus.imem_valid_i) mem_busy = 0;
      else if (mem_busy) mem_cnt--;
      if (obs_req && drv_gnt) begin
        lat      = mem_lat_rand ? int'($urandom_range(1, 4)) : mem_lat;
        mem_busy = 1;
        mem_addr = obs_addr;
        mem_cnt  = lat - 1;
      end
    end

    // model
    if (drv_rst) begin
      m_started = 0; m_out = 0; m_stale = 0; m_sv = 0; m_mis = 0;
      m_pc = RV; m_inflight = '0; m_spc = '0; m_sinstr = NOP;
    end else begin
      granted = exp_req && drv_gnt;
      arrived = m_out && bus.imem_valid_i;
      if (m_sv && drv_ready) m_sv = 0;
      if (arrived) begin
        if (!m_stale && !drv_redirect) begin
          m_sv = 1; m_spc = m_inflight; m_sinstr = bus.imem_rdata_i;
          m_pc = m_inflight + 32'd4;
        end
        m_out = 0; m_stale = 0;
      end
      if (granted) begin
        m_out = 1; m_stale = 0; m_inflight = m_pc;
      end
      if (drv_redirect) begin
        m_pc = drv_target & ~32'h3;
        m_sv = 0;
        if (m_out) m_stale = 1;
      end
      m_mis = drv_redirect && ((drv_target % 4) != 0);
      m_started = 1;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    drv_rst = 1; drv_redirect = 0; drv_ready = 1; drv_gnt = 1;
    mem_force = 0; mem_lat_rand = 0; mem_lat = 1;
    tick();
    tick();
    drv_rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (obs_req !== 1'b0) $display("FAIL reset_req got=%0h exp=0", obs_req); else passed++;
    total++; if (obs_addr !== RV) $display("FAIL reset_addr got=%h exp=%h", obs_addr, RV); else passed++;
    total++; if (obs_v !== 1'b0) $display("FAIL reset_valid got=%0h exp=0", obs_v); else passed++;
    total++; if (obs_pc !== 32'h0) $display("FAIL reset_pc got=%h exp=0", obs_pc); else passed++;
    total++; if (obs_instr !== NOP) $display("FAIL reset_instr got=%h exp=%h", obs_instr, NOP); else passed++;
    total++; if (obs_mis !== 1'b0) $display("FAIL reset_misalign got=%0h exp=0", obs_mis); else passed++;
    tick();
    total++; if (obs_req !== 1'b0) $display("FAIL idle_req got=%0h exp=0", obs_req); else passed++;
    tick();
    total++; if (obs_req !== 1'b1 || obs_addr !== RV)
      $display("FAIL first_req got=%0h/%h exp=1/%h", obs_req, obs_addr, RV); else passed++;
    $display("test_reset done");
  endtask

  task automatic test_stream();
    logic [31:0] req_addrs[$], vpc[$], vinstr[$];
    int vcyc[$];
    do_reset();
    for (int i = 0; i < 8; i++) begin
      tick();
      if (obs_req) req_addrs.push_back(obs_addr);
      if (obs_v) begin vpc.push_back(obs_pc); vinstr.push_back(obs_instr); vcyc.push_back(i); end
    end
    for (int k = 0; k < 3; k++) begin
      total++; if (k >= req_addrs.size() || req_addrs[k] !== 32'(4 * k))
        $display("FAIL stream_addr%0d got=%h exp=%h", k, (k < req_addrs.size()) ? req_addrs[k] : 32'hx, 32'(4 * k)); else passed++;
      total++; if (k >= vpc.size() || vpc[k] !== 32'(4 * k) || vcyc[k] != 3 + 2 * k || vinstr[k] !== word_at(32'(4 * k)))
        $display("FAIL stream_out%0d got pc=%h cyc=%0d exp pc=%h cyc=%0d", k,
                 (k < vpc.size()) ? vpc[k] : 32'hx, (k < vcyc.size()) ? vcyc[k] : -1, 32'(4 * k), 3 + 2 * k); else passed++;
    end
    $display("test_stream done: %0d requests, %0d outputs", req_addrs.size(), vpc.size());
  endtask

  task automatic test_stall();
    do_reset();
    drv_ready = 0;
    tick(); tick(); tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if (obs_req !== 1'b0 || obs_v !== 1'b1 || obs_pc !== 32'h0 || obs_instr !== word_at(32'h0))
        $display("FAIL stall_hold%0d got req=%0h v=%0h pc=%h instr=%h exp req=0 v=1 pc=0 instr=%h",
                 i, obs_req, obs_v, obs_pc, obs_instr, word_at(32'h0)); else passed++;
    end
    drv_ready = 1;
    tick();
    total++; if (obs_req !== 1'b1 || obs_addr !== 32'h4)
      $display("FAIL stall_release got=%0h/%h exp=1/00000004", obs_req, obs_addr); else passed++;
    $display("test_stall done");
  endtask

  task automatic test_redirect_wait();
    do_reset();
    mem_lat = 4;
    tick(); tick();
    drv_redirect = 1; drv_target = 32'h100;
    tick();
    drv_redirect = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (obs_req !== 1'b0 || obs_v !== 1'b0)
        $display("FAIL drain%0d got req=%0h v=%0h exp req=0 v=0", i, obs_req, obs_v); else passed++;
    end
    tick();
    total++; if (obs_req !== 1'b1 || obs_addr !== 32'h100 || obs_v !== 1'b0)
      $display("FAIL drain_refetch got req=%0h addr=%h v=%0h exp 1/00000100/0", obs_req, obs_addr, obs_v); else passed++;
    $display("test_redirect_wait done");
  endtask

  task automatic test_redirect_with_data();
    do_reset();
    tick(); tick();
    mem_force = 1; mem_force_data = 32'hDEAD_BEEF;
    drv_redirect = 1; drv_target = 32'h40;
    tick();
    mem_force = 0; drv_redirect = 0;
    tick();
    total++; if (obs_req !== 1'b1 || obs_addr !== 32'h40 || obs_v !== 1'b0 || obs_instr === 32'hDEAD_BEEF)
      $display("FAIL squash_refetch got req=%0h addr=%h v=%0h instr=%h exp 1/00000040/0/not deadbeef",
               obs_req, obs_addr, obs_v, obs_instr); else passed++;
    tick(); tick();
    total++; if (obs_v !== 1'b1 || obs_pc !== 32'h40 || obs_instr !== word_at(32'h40))
      $display("FAIL squash_next got v=%0h pc=%h instr=%h exp 1/00000040/%h", obs_v, obs_pc, obs_instr, word_at(32'h40)); else passed++;
    $display("test_redirect_with_data done");
  endtask

  task automatic test_misalign();
    do_reset();
    tick();
    drv_gnt = 0; drv_redirect = 1; drv_target = 32'h202;
    tick();
    drv_gnt = 1; drv_redirect = 0;
    tick();
    total++; if (obs_mis !== 1'b1 || obs_req !== 1'b1 || obs_addr !== 32'h200)
      $display("FAIL misalign_pulse got mis=%0h req=%0h addr=%h exp 1/1/00000200", obs_mis, obs_req, obs_addr); else passed++;
    tick();
    total++; if (obs_mis !== 1'b0) $display("FAIL misalign_clear got=%0h exp=0", obs_mis); else passed++;
    $display("test_misalign done");
  endtask

  task automatic test_wrap();
    do_reset();
    drv_redirect = 1; drv_target = 32'hFFFF_FFFC;
    tick();
    drv_redirect = 0;
    tick();
    total++; if (obs_req !== 1'b1 || obs_addr !== 32'hFFFF_FFFC)
      $display("FAIL wrap_req got=%0h/%h exp=1/fffffffc", obs_req, obs_addr); else passed++;
    tick(); tick();
    total++; if (obs_v !== 1'b1 || obs_pc !== 32'hFFFF_FFFC || obs_req !== 1'b1 || obs_addr !== 32'h0)
      $display("FAIL wrap_next got v=%0h pc=%h req=%0h addr=%h exp 1/fffffffc/1/00000000", obs_v, obs_pc, obs_req, obs_addr); else passed++;
    $display("test_wrap done");
  endtask

  task automatic test_reset_in_wait();
    do_reset();
    tick(); tick(); tick();
    mem_lat = 3;
    tick();
    total++; if (obs_req !== 1'b1 || obs_addr !== 32'h4)
      $display("FAIL rstwait_req got=%0h/%h exp=1/00000004", obs_req, obs_addr); else passed++;
    drv_rst = 1;
    tick();
    drv_rst = 0;
    tick();
    total++; if (obs_req !== 1'b0 || obs_addr !== RV || obs_v !== 1'b0 || obs_pc !== 32'h0 || obs_instr !== NOP || obs_mis !== 1'b0)
      $display("FAIL rstwait_outputs got req=%0h addr=%h v=%0h pc=%h instr=%h mis=%0h exp reset values",
               obs_req, obs_addr, obs_v, obs_pc, obs_instr, obs_mis); else passed++;
    tick();
    total++; if (obs_req !== 1'b1 || obs_addr !== RV)
      $display("FAIL rstwait_restart got=%0h/%h exp=1/%h", obs_req, obs_addr, RV); else passed++;
    $display("test_reset_in_wait done");
  endtask

  task automatic test_random();
    int fails_before;
    fails_before = total - passed;
    do_reset();
    mem_lat_rand = 1;
    for (int i = 0; i < 3000; i++) begin
      drv_ready    = ($urandom_range(0, 99) < 75);
      drv_gnt      = ($urandom_range(0, 99) < 60);
      drv_redirect = ($urandom_range(0, 99) < 10);
      drv_rst      = ($urandom_range(0, 299) == 0);
      case ($urandom_range(0, 2))
        0:       drv_target = $urandom;
        1:       drv_target = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
        default: drv_target = 32'($urandom_range(0, 63));
      endcase
      tick();
      total++; if (obs_req !== exp_req) $display("FAIL rnd_req cyc=%0d got=%0h exp=%0h", i, obs_req, exp_req); else passed++;
      total++; if (obs_addr !== exp_addr) $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", i, obs_addr, exp_addr); else passed++;
      total++; if (obs_v !== exp_v) $display("FAIL rnd_valid cyc=%0d got=%0h exp=%0h", i, obs_v, exp_v); else passed++;
      total++; if (obs_pc !== exp_pc) $display("FAIL rnd_pc cyc=%0d got=%h exp=%h", i, obs_pc, exp_pc); else passed++;
      total++; if (obs_instr !== exp_instr) $display("FAIL rnd_instr cyc=%0d got=%h exp=%h", i, obs_instr, exp_instr); else passed++;
      total++; if (obs_mis !== exp_mis) $display("FAIL rnd_misalign cyc=%0d got=%0h exp=%0h", i, obs_mis, exp_mis); else passed++;
    end
    drv_rst = 0; drv_redirect = 0;
    $display("test_random done: %0d new failures", (total - passed) - fails_before);
  endtask

  initial begin
    rst = 1'b1;
    bus.redirect_i = 1'b0; bus.redirect_pc_i = '0; bus.id_ready_i = 1'b1;
    bus.imem_gnt_i = 1'b0; bus.imem_valid_i = 1'b0; bus.imem_rdata_i = '0;
    @(negedge clk);
    test_reset();
    test_stream();
    test_stall();
    test_redirect_wait();
    test_redirect_with_data();
    test_misalign();
    test_wrap();
    test_reset_in_wait();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
